uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte queue feeding the UART transmitter: producers push bytes at any rate, block pops them
//  and launches one UART_Tx frame at a time via tx_start/tx_data, pacing on tx_busy.
//  Sits directly upstream of the UART top's tx_start/tx_data/tx_busy ports; removes need for
//  producers to poll tx_busy.
// PARAMETERS
//  DEPTH     16   queue entries; power of two, >= 2
//  AW        $clog2(DEPTH)  pointer width (derived, localparam)
//  BUSY_TO   3    cycles to wait for tx_busy to rise after tx_start before assuming frame done
// PORTS
//  clk       in   1   system clock, rising edge
//  rst       in   1   asynchronous, active-low reset (0 = reset)
//  wr_en     in   1   push request, sampled each clk
//  wr_data   in   8   byte to push, valid with wr_en
//  full      out  1   count == DEPTH
//  empty     out  1   count == 0
//  overflow  out  1   1-cycle pulse: wr_en while full (byte dropped)
//  tx_busy   in   1   from UART_Tx, high while frame in flight
//  tx_start  out  1   1-cycle launch pulse to UART_Tx
//  tx_data   out  8   registered byte to UART_Tx, stable from tx_start until tx_busy falls
//  level     out  AW+1 occupancy (only with UART_TXQ_LEVEL_EN)
// BEHAVIOUR
//  Reset (rst=0, async): wr/rd ptr=0, count=0, state=IDLE, tx_start=0, tx_data=8'h00,
//   overflow=0, full=0, empty=1; queue contents don't-care. In-flight frame abandoned, no re-send.
//  Storage: DEPTH x 8 array, wr_ptr/rd_ptr AW bits, natural wrap DEPTH-1 -> 0; count AW+1 bits.
//  Push: wr_en && !full -> mem[wr_ptr]<=wr_data, wr_ptr++. wr_en && full -> drop, overflow=1 next
//   cycle for 1 cycle. full uses registered count: push while full is rejected even if a pop
//   occurs the same cycle.
//  Pop: occurs only in IDLE->LAUNCH transition; tx_data<=mem[rd_ptr], rd_ptr++.
//  Simultaneous push+pop (not full): count unchanged, both pointers advance.
//  FSM (registered):
//   IDLE      : !empty && !tx_busy -> pop, LAUNCH; else stay.
//   LAUNCH    : tx_start=1 this cycle only -> WAIT_BUSY (timer cleared).
//   WAIT_BUSY : tx_busy=1 -> WAIT_DONE; timer==BUSY_TO-1 -> IDLE (timeout); else timer++.
//   WAIT_DONE : tx_busy=0 -> IDLE.
//  Latency: byte pushed into empty queue with tx_busy=0 -> tx_start high 2 clks after push edge
//   (push edge, IDLE sees !empty & pops, LAUNCH drives tx_start).
//  Back-to-back: next pop no earlier than cycle after tx_busy falls; tx_start never asserted
//   while tx_busy=1. FIFO order strictly preserved.
//  full/empty/level are combinational decodes of registered count (no wr_en bypass).
// CONFIGURATION
//  UART_TXQ_LEVEL_EN defined: port level[AW:0] present, equals count (0..DEPTH).
//  Not defined: port level absent; all other behaviour identical.
// STRUCTURE
//  Shared package uart_pkg: FSM state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE), UART_DW=8.
//  One sub-module natural: uart_txq_mem (DEPTH x 8 register array, 1 write port,
//   1 async read port); FSM, pointers and count live in uart_tx_fifo.
// TESTING
//  1 Push 8'hA5 into empty queue, tx_busy model rises 1 clk after tx_start, holds 10 clks ->
//    exactly one tx_start, 2 clks after push; tx_data=8'hA5 stable until tx_busy falls; empty=1 after.
//  2 Hold tx_busy=1, push 17 bytes 8'h00..8'h10 -> full=1 after 16th; 17th gives one overflow
//    pulse; release busy -> 16 frames 8'h00..8'h0F in order, 8'h10 never sent.
//  3 Push 3 bytes, fake UART never raises tx_busy -> each launch times out after BUSY_TO clks;
//    three tx_start pulses, order 1,2,3, queue empty.
//  4 Full queue, push and pop same cycle -> push rejected, overflow pulse, count DEPTH-1.
//  5 Assert rst=0 asynchronously during WAIT_DONE with 5 bytes queued -> outputs at reset values
//    immediately; after release no tx_start until new push.
//  6 UART_TXQ_LEVEL_EN build: push 5, drain 2 -> level 5 then 3; wrap pointers past DEPTH
//    (push/pop 40 bytes) -> data integrity and level correct throughout.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared constants for the UART transmit queue: data width, FSM
//           state encoding and the timeout-counter width helper.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DW = 8;

  // Transmit-queue launcher FSM encoding
  localparam int         ST_W         = 2;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Width of a counter that must reach busy_to-1; never narrower than 1 bit
  function automatic int timer_width(input int busy_to);
    return (busy_to > 1) ? $clog2(busy_to) : 1;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_txq_mem.sv
`default_nettype none
// ============================================================================
// Module  : uart_txq_mem
// Purpose : DEPTH x UART_DW register array, one synchronous write port and
//           one asynchronous read port, backing the UART transmit queue.
// Revision: 1.0 - initial release
// ============================================================================
module uart_txq_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [UART_DW-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [UART_DW-1:0] rdata
);

  // Contents are don't-care after reset, so the array carries no reset
  logic [UART_DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : uart_txq_mem
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Purpose : Byte queue in front of the UART transmitter; pops one byte at a
//           time and launches a frame via tx_start/tx_data, pacing on tx_busy.
//           Build option UART_TXQ_LEVEL_EN adds the 'level' occupancy port.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int BUSY_TO = 3,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [UART_DW-1:0] tx_data
`ifdef UART_TXQ_LEVEL_EN
  ,
  output logic [AW:0]        level
`endif
);

  localparam int              TW        = timer_width(BUSY_TO);
  localparam logic [TW-1:0]   C_TO_LAST = TW'(BUSY_TO - 1);
  localparam logic [AW:0]     C_FULL    = (AW + 1)'(DEPTH);

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic [ST_W-1:0]    r_state;
  logic [TW-1:0]      r_timer;
  logic               r_overflow;
  logic [UART_DW-1:0] r_tx_data;

  logic               w_push;
  logic               w_pop;
  logic [UART_DW-1:0] w_rd_data;

  // Status flags decode the registered count only; a same-cycle pop never
  // rescues a push that arrives while full.
  assign full  = (r_count == C_FULL);
  assign empty = (r_count == '0);

  assign w_push = wr_en && !full;
  assign w_pop  = (r_state == ST_IDLE) && !empty && !tx_busy;

  uart_txq_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (wr_data),
    .raddr (r_rd_ptr),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Launcher: a frame that never raises tx_busy is treated as finished after
  // BUSY_TO cycles so an absent or stalled transmitter cannot wedge the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_tx_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_rd_data;
            r_state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_timer <= '0;
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_timer == C_TO_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_start = (r_state == ST_LAUNCH);
  assign tx_data  = r_tx_data;
  assign overflow = r_overflow;

`ifdef UART_TXQ_LEVEL_EN
  assign level = r_count;
`endif

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Purpose : Self-checking bench for uart_tx_fifo with a fake UART transmitter
//           and a byte scoreboard. Level checks compile in with UART_TXQ_LEVEL_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH   = 16;
  localparam int BUSY_TO = 3;

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic       wr_en      = 1'b0;
  logic [7:0] wr_data    = 8'h00;
  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
`ifdef UART_TXQ_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         starts     = 0;
  int         ovf_cnt    = 0;
  int         cyc        = 0;
  int         busy_hold  = 10;
  int         hold_left  = 0;
  bit         busy_never = 1'b0;
  bit         pending    = 1'b0;
  logic [7:0] last_byte  = 8'h00;
  logic [7:0] sb[$];
  int         start_cyc[$];

  assign tx_busy = force_busy | model_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH   (DEPTH),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data)
`ifdef UART_TXQ_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Fake transmitter: busy rises one cycle after tx_start and holds busy_hold cycles
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      model_busy = 1'b0;
      pending    = 1'b0;
      hold_left  = 0;
    end else begin
      if (overflow) ovf_cnt++;
      if (tx_start) begin
        starts++;
        start_cyc.push_back(cyc);
        check_eq("start_while_busy", tx_busy, 0);
        if (sb.size() == 0) begin
          check_eq("unexpected_start", tx_start, 0);
        end else begin
          last_byte = sb.pop_front();
          check_eq("tx_data", tx_data, last_byte);
        end
        pending = !busy_never;
      end else if (pending) begin
        pending    = 1'b0;
        model_busy = 1'b1;
        hold_left  = busy_hold;
      end else if (model_busy) begin
        check_eq("tx_data_stable", tx_data, last_byte);
        hold_left--;
        if (hold_left == 0) model_busy = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) sb.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || pending || model_busy || !empty) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (BUSY_TO + 3) @(negedge clk);
    #1;
    check_eq({tag, "_sb_left"}, sb.size(), 0);
    check_eq({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int o0;
    int n;

    // Reset values
    #1;
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_overflow", overflow, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte, launch latency and data hold
    busy_hold = 10;
    s0 = starts;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    sb.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check_eq("t1_start_cyc1", tx_start, 0);
    check_eq("t1_not_empty", empty, 0);
    @(negedge clk);
    #1;
    check_eq("t1_start_cyc2", tx_start, 1);
    check_eq("t1_data", tx_data, 8'hA5);
    drain("t1");
    check_eq("t1_starts", starts - s0, 1);

    // 2: fill while busy, overflow on 17th, ordered drain
    force_busy = 1'b1;
    s0 = starts;
    o0 = ovf_cnt;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    #1;
    check_eq("t2_full", full, 1);
    push(8'h10, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("t2_ovf_pulses", ovf_cnt - o0, 1);
    check_eq("t2_still_full", full, 1);
    check_eq("t2_no_start", starts - s0, 0);
    force_busy = 1'b0;
    drain("t2");
    check_eq("t2_starts", starts - s0, 16);

    // 3: transmitter never answers, launches time out
    busy_never = 1'b1;
    s0 = starts;
    for (int i = 1; i <= 3; i++) push(8'(i), 1'b1);
    drain("t3");
    check_eq("t3_starts", starts - s0, 3);
    check_eq("t3_timeout_gap",
             start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2], BUSY_TO + 2);
    busy_never = 1'b0;

    // 4: push and pop in the same cycle while full
    force_busy = 1'b1;
    s0 = starts;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b1);
    #1;
    check_eq("t4_full", full, 1);
    o0 = ovf_cnt;
    @(negedge clk);
    wr_en      = 1'b1;
    wr_data    = 8'hEE;
    force_busy = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check_eq("t4_full_after", full, 0);
    check_eq("t4_start", tx_start, 1);
`ifdef UART_TXQ_LEVEL_EN
    check_eq("t4_level", level, DEPTH - 1);
`endif
    @(negedge clk);
    #1;
    check_eq("t4_ovf_pulses", ovf_cnt - o0, 1);
    drain("t4");
    check_eq("t4_starts", starts - s0, 16);

    // 5: async reset during WAIT_DONE with bytes queued
    busy_hold = 40;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 1'b1);
    repeat (5) @(negedge clk);
    #1;
    check_eq("t5_queued", empty, 0);
    check_eq("t5_in_frame", tx_busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_rst_empty", empty, 1);
    check_eq("t5_rst_full", full, 0);
    check_eq("t5_rst_tx_start", tx_start, 0);
    check_eq("t5_rst_tx_data", tx_data, 8'h00);
    check_eq("t5_rst_overflow", overflow, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst       = 1'b1;
    busy_hold = 10;
    s0 = starts;
    repeat (10) @(negedge clk);
    #1;
    check_eq("t5_no_resend", starts - s0, 0);
    check_eq("t5_empty_after", empty, 1);
    push(8'h5A, 1'b1);
    drain("t5");
    check_eq("t5_starts", starts - s0, 1);

    // 6: partial drain and pointer wrap with data integrity
    force_busy = 1'b1;
    s0 = starts;
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 1'b1);
    #1;
`ifdef UART_TXQ_LEVEL_EN
    check_eq("t6_level5", level, 5);
`endif
    force_busy = 1'b0;
    n = 0;
    while (starts - s0 < 2 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("t6_two_sent", starts - s0, 2);
    check_eq("t6_not_empty", empty, 0);
`ifdef UART_TXQ_LEVEL_EN
    check_eq("t6_level3", level, 3);
`endif
    force_busy = 1'b0;
    drain("t6a");
    for (int b = 0; b < 4; b++) begin
      force_busy = 1'b1;
      for (int i = 0; i < 10; i++) push(8'((b * 10 + i) * 7) ^ 8'h5C, 1'b1);
      #1;
      check_eq("t6_batch_not_full", full, 0);
`ifdef UART_TXQ_LEVEL_EN
      check_eq("t6_batch_level", level, 10);
`endif
      force_busy = 1'b0;
      drain("t6_batch");
`ifdef UART_TXQ_LEVEL_EN
      check_eq("t6_batch_level0", level, 0);
`endif
    end
    check_eq("t6_starts", starts - s0, 45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_fifo
`default_nettype wire
